// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, screen size for the game block,
// and the 24-bit colour type with a few named colours.
package vga_pkg;

   localparam int COORD_W = 10;
   localparam int COORD_MAX = 1 << COORD_W;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
   localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

   localparam int SCREEN_WIDTH  = VGA_H_ACTIVE;
   localparam int SCREEN_HEIGHT = VGA_V_ACTIVE;

   typedef logic [23:0] rgb_t;

   localparam rgb_t COLOR_BLACK  = 24'h000000;
   localparam rgb_t COLOR_WHITE  = 24'hFFFFFF;
   localparam rgb_t COLOR_RED    = 24'hFF0000;
   localparam rgb_t COLOR_BLUE   = 24'h0000FF;
   localparam rgb_t COLOR_YELLOW = 24'hFFFF00;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter plus the decoded
// visible, sync and end-of-axis flags for the current count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE   = VGA_H_ACTIVE,
   parameter int FP       = VGA_H_FP,
   parameter int SYNC     = VGA_H_SYNC,
   parameter int BP       = VGA_H_BP,
   parameter int SYNC_POL = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               wrap_en,
   output logic [COORD_W-1:0] count,
   output logic               active,
   output logic               sync,
   output logic               last
);

   typedef logic [COORD_W:0] wide_t;

   localparam int                 TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [COORD_W-1:0] LAST_VAL   = COORD_W'(TOTAL - 1);
   localparam wide_t              ACTIVE_END = wide_t'(ACTIVE);
   localparam wide_t              SYNC_START = wide_t'(ACTIVE + FP);
   localparam wide_t              SYNC_END   = wide_t'(ACTIVE + FP + SYNC);
   localparam logic               POL        = SYNC_POL[0];

   // wrap_en is the carry from the faster axis (tied high for horizontal)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (en && wrap_en) begin
         count <= last ? '0 : count + COORD_W'(1);
      end
   end

   assign last   = (count == LAST_VAL);
   assign active = (wide_t'(count) < ACTIVE_END);
   assign sync   = ((wide_t'(count) >= SYNC_START) && (wide_t'(count) < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_driver.sv
// 640x480@60 VGA timing generator: pixel-rate divider, x/y counters for the renderer,
// and one registered stage that aligns colour, sync and blank at the pins.
module vga_timing_driver
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int SYNC_POL = 0,
   parameter int CLK_DIV  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [23:0]        rgb_in,
   output logic [COORD_W-1:0] x_pixel,
   output logic [COORD_W-1:0] y_pixel,
   output logic               active_pixels,
   output logic               pix_en,
   output logic               frame_tick,
   output logic [7:0]         vga_r,
   output logic [7:0]         vga_g,
   output logic [7:0]         vga_b,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_blank_n
);

   localparam int                 H_TOTAL    = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int                 V_TOTAL    = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam logic [3:0]         DIV_LAST   = 4'(CLK_DIV - 1);
   localparam logic [COORD_W-1:0] V_LAST_VIS = COORD_W'(V_ACTIVE - 1);
   localparam logic               POL        = SYNC_POL[0];

   generate
      if (H_TOTAL > COORD_MAX) begin : g_h_total_too_big
         $error("vga_timing_driver: H_TOTAL exceeds 10-bit counter range");
      end
      if (V_TOTAL > COORD_MAX) begin : g_v_total_too_big
         $error("vga_timing_driver: V_TOTAL exceeds 10-bit counter range");
      end
      if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_clk_div_range
         $error("vga_timing_driver: CLK_DIV must be 1..16");
      end
   endgenerate

   logic [3:0]         div_cnt;
   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic               h_active;
   logic               h_sync;
   logic               h_last;
   logic               v_active;
   logic               v_sync;
   logic               v_last_unused;

   // With CLK_DIV=1 the compare is 0==0, so pix_en stays high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= pix_en ? '0 : div_cnt + 4'd1;
      end
   end

   assign pix_en = (div_cnt == DIV_LAST);

   vga_axis_counter #(
      .ACTIVE   (H_ACTIVE),
      .FP       (H_FP),
      .SYNC     (H_SYNC),
      .BP       (H_BP),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .clk     (clk),
      .rst     (rst),
      .en      (pix_en),
      .wrap_en (1'b1),
      .count   (h_cnt),
      .active  (h_active),
      .sync    (h_sync),
      .last    (h_last)
   );

   vga_axis_counter #(
      .ACTIVE   (V_ACTIVE),
      .FP       (V_FP),
      .SYNC     (V_SYNC),
      .BP       (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .clk     (clk),
      .rst     (rst),
      .en      (pix_en),
      .wrap_en (h_last),
      .count   (v_cnt),
      .active  (v_active),
      .sync    (v_sync),
      .last    (v_last_unused)
   );

   assign x_pixel       = h_cnt;
   assign y_pixel       = v_cnt;
   assign active_pixels = h_active && v_active;
   assign frame_tick    = pix_en && h_last && (v_cnt == V_LAST_VIS);

   // Pin stage: rgb_in is combinational from x/y, so it is captured here alongside sync/blank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vga_hs                <= ~POL;
         vga_vs                <= ~POL;
         vga_blank_n           <= 1'b0;
         {vga_r, vga_g, vga_b} <= COLOR_BLACK;
      end else if (pix_en) begin
         vga_hs                <= h_sync;
         vga_vs                <= v_sync;
         vga_blank_n           <= active_pixels;
         {vga_r, vga_g, vga_b} <= active_pixels ? rgb_in : COLOR_BLACK;
      end
   end

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver on a shrunken raster so whole frames fit the cycle budget;
// a bench-side timing model feeds a scoreboard of expected pin words.
module tb_vga_timing_driver;

   localparam int   HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int   VA = 8,  VF = 2, VS = 2, VB = 2;
   localparam int   HT = HA + HF + HS + HB;
   localparam int   VT = VA + VF + VS + VB;
   localparam int   DIV = 2;
   localparam logic POL = 1'b0;
   localparam int   FRAME_CLK = HT * VT * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] rgb_in = 24'h0;
   logic [9:0]  x_pixel, y_pixel;
   logic        active_pixels, pix_en, frame_tick;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n;

   int checks = 0;
   int errors = 0;

   logic [26:0] pin_q[$];
   logic [26:0] exp_pins;
   logic        pend;
   int          m_div, m_h, m_v;
   int          cyc, ticks, rgb_mode;
   logic        prev_hs, prev_vs;
   int          hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];

   always #5 clk = ~clk;

   vga_timing_driver #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_POL (0),  .CLK_DIV (DIV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rgb_in        (rgb_in),
      .x_pixel       (x_pixel),
      .y_pixel       (y_pixel),
      .active_pixels (active_pixels),
      .pix_en        (pix_en),
      .frame_tick    (frame_tick),
      .vga_r         (vga_r),
      .vga_g         (vga_g),
      .vga_b         (vga_b),
      .vga_hs        (vga_hs),
      .vga_vs        (vga_vs),
      .vga_blank_n   (vga_blank_n)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_active(input int h, input int v);
      return (h < HA) && (v < VA);
   endfunction

   function automatic logic exp_hs(input int h);
      return ((h >= HA + HF) && (h < HA + HF + HS)) ? POL : ~POL;
   endfunction

   function automatic logic exp_vs(input int v);
      return ((v >= VA + VF) && (v < VA + VF + VS)) ? POL : ~POL;
   endfunction

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic reset_model();
      m_div = 0; m_h = 0; m_v = 0;
      pin_q.delete();
      exp_pins = {~POL, ~POL, 1'b0, 24'h0};
      pend = 1'b0;
      prev_hs = ~POL; prev_vs = ~POL;
      hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete();
      ticks = 0; cyc = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_x"}, 32'(x_pixel), 32'd0);
      check({tag, "_y"}, 32'(y_pixel), 32'd0);
      check({tag, "_active"}, 32'(active_pixels), 32'd1);
      check({tag, "_pix_en"}, 32'(pix_en), 32'd0);
      check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
      check({tag, "_pins"}, 32'({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}),
            32'({~POL, ~POL, 1'b0, 24'h0}));
   endtask

   // Called at a negedge: compare DUT against the model, drive rgb_in, push expectation, advance
   task automatic step_cycle();
      logic [26:0] got;
      logic        act;
      logic        pm;
      if (pend) begin
         if (pin_q.size() == 0) check("scoreboard_underflow", 32'd0, 32'd1);
         else exp_pins = pin_q.pop_front();
      end
      got = {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
      check("pins", 32'(got), 32'(exp_pins));
      act = exp_active(m_h, m_v);
      pm  = (m_div == DIV - 1);
      check("x_pixel", 32'(x_pixel), 32'(m_h));
      check("y_pixel", 32'(y_pixel), 32'(m_v));
      check("active_pixels", 32'(active_pixels), 32'(act));
      check("pix_en", 32'(pix_en), 32'(pm));
      check("frame_tick", 32'(frame_tick), 32'(pm && (m_h == HT - 1) && (m_v == VA - 1)));
      if (frame_tick === 1'b1) ticks++;
      if (vga_hs !== prev_hs) begin
         if (vga_hs === POL) hs_fall.push_back(cyc); else hs_rise.push_back(cyc);
      end
      if (vga_vs !== prev_vs) begin
         if (vga_vs === POL) vs_fall.push_back(cyc); else vs_rise.push_back(cyc);
      end
      prev_hs = vga_hs;
      prev_vs = vga_vs;
      rgb_in = (rgb_mode == 0) ? 24'hFF0000 : 24'($urandom);
      if (pm) pin_q.push_back({exp_hs(m_h), exp_vs(m_v), act, act ? rgb_in : 24'h0});
      pend = pm;
      if (pm) begin
         if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
         end else begin
            m_h++;
         end
      end
      m_div = (m_div == DIV - 1) ? 0 : m_div + 1;
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      rst = 1'b0;
      rgb_in = 24'h0;
      rgb_mode = 0;
      #12;
      check_reset_outputs("por");
      $display("step: power-on reset values checked at t=%0t", $time);

      @(negedge clk);
      rst = 1'b1;
      reset_model();
      for (int i = 0; i < 2 * FRAME_CLK + 200; i++) step_cycle();
      check("frame_ticks_2frames", 32'(ticks), 32'd2);
      check("hs_first_fall_clk", 32'(qget(hs_fall, 0)), 32'(2 * (HA + HF + 1)));
      check("hs_low_clk", 32'(qget(hs_rise, 0) - qget(hs_fall, 0)), 32'(HS * DIV));
      check("hs_period_clk", 32'(qget(hs_fall, 1) - qget(hs_fall, 0)), 32'(HT * DIV));
      check("vs_first_fall_clk", 32'(qget(vs_fall, 0)), 32'(2 * ((VA + VF) * HT + 1)));
      check("vs_low_clk", 32'(qget(vs_rise, 0) - qget(vs_fall, 0)), 32'(VS * HT * DIV));
      check("vs_period_clk", 32'(qget(vs_fall, 1) - qget(vs_fall, 0)), 32'(FRAME_CLK));
      $display("step: two red frames, ticks=%0d hs_falls=%0d vs_falls=%0d", ticks, hs_fall.size(), vs_fall.size());

      rgb_mode = 1;
      for (int i = 0; i < 2 * FRAME_CLK; i++) begin
         if ((m_h == 10) && (m_v == 3)) break;
         step_cycle();
      end
      check("pre_rst_x", 32'(x_pixel), 32'd10);
      check("pre_rst_y", 32'(y_pixel), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      check_reset_outputs("held_rst");
      rst = 1'b1;
      reset_model();
      $display("step: mid-frame reset at x=10 y=3 released at t=%0t", $time);

      for (int i = 0; i < FRAME_CLK + 100; i++) step_cycle();
      check("post_rst_hs_fall_clk", 32'(qget(hs_fall, 0)), 32'(2 * (HA + HF + 1)));
      check("post_rst_frame_ticks", 32'(ticks), 32'd1);
      $display("step: random-colour frame after reset, ticks=%0d", ticks);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
